// File: rtl/veggie_slice_ctrl_if.sv
// Handshake/data bundle between the blade/spawn logic and one veggie controller.
// Optional SLICE_SCORE_EN adds the score counter and slice pulse.
interface veggie_slice_ctrl_if;
  logic        frame_tick_in;
  logic        launch_in;
  logic [10:0] launch_x_in;
  logic [4:0]  launch_vx_in;
  logic        slash_valid_in;
  logic [10:0] slash_run_in;
  logic [9:0]  slash_rise_in;
  logic        hit_in;
  logic [10:0] x_out;
  logic [9:0]  y_out;
  logic [7:0]  sep_out;
  logic        split_out;
  logic [10:0] run_out;
  logic [9:0]  rise_out;
  logic        veggie_gone_out;
  logic        busy_out;
`ifdef SLICE_SCORE_EN
  logic [15:0] score_out;
  logic        slice_pulse_out;
`endif

  modport master (
`ifdef SLICE_SCORE_EN
    input  score_out, slice_pulse_out,
`endif
    output frame_tick_in, launch_in, launch_x_in, launch_vx_in,
           slash_valid_in, slash_run_in, slash_rise_in, hit_in,
    input  x_out, y_out, sep_out, split_out, run_out, rise_out,
           veggie_gone_out, busy_out
  );

  modport slave (
`ifdef SLICE_SCORE_EN
    output score_out, slice_pulse_out,
`endif
    input  frame_tick_in, launch_in, launch_x_in, launch_vx_in,
           slash_valid_in, slash_run_in, slash_rise_in, hit_in,
    output x_out, y_out, sep_out, split_out, run_out, rise_out,
           veggie_gone_out, busy_out
  );
endinterface

// File: rtl/veggie_slice_ctrl.sv
// Per-veggie lifecycle: launch, per-frame ballistic update, slice into halves, retire.
// Optional SLICE_SCORE_EN adds a saturating slice score and a one-cycle slice pulse.
module veggie_slice_ctrl #(
  parameter int SCREEN_W  = 1024,
  parameter int SCREEN_H  = 768,
  parameter int SPRITE_H  = 256,
  parameter int GRAVITY   = 1,
  parameter int LAUNCH_VY = 24,
  parameter int SPLIT_DX  = 2
) (
  input logic pixel_clk_in,
  input logic rst_in,
  veggie_slice_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, FLYING, SLICED, GONE} state_t;

  localparam logic signed [11:0] Y_START  = 12'(SCREEN_H);
  localparam logic signed [11:0] RETIRE_Y = 12'(SCREEN_H + SPRITE_H / 2);
  localparam logic signed [12:0] X_MAX    = 13'(SCREEN_W - 1);

  state_t state, state_nxt;
  logic [10:0]       x, x_nxt;
  logic signed [11:0] y, y_nxt;
  logic signed [7:0] vy, vy_nxt;
  logic signed [4:0] vx, vx_nxt;
  logic [7:0]        sep, sep_nxt;
  logic              split, split_nxt;
  logic [10:0]       run, run_nxt;
  logic [9:0]        rise, rise_nxt;
  logic              gone, gone_nxt;

  logic signed [11:0] y_step;
  logic signed [8:0]  vy_dec;
  logic signed [7:0]  vy_sat;
  logic signed [12:0] x_sum;
  logic [10:0]        x_clamp;
  logic               x_bounce;
  logic signed [4:0]  vx_neg;
  logic [8:0]         sep_sum;
  logic [7:0]         sep_sat;
  logic               retire;
  logic               accept;

  assign y_step  = y - {{4{vy[7]}}, vy};
  assign vy_dec  = {vy[7], vy} - 9'(GRAVITY);
  assign vy_sat  = (vy_dec < -9'sd128) ? -8'sd128 : vy_dec[7:0];
  assign x_sum   = $signed({2'b00, x}) + $signed({{8{vx[4]}}, vx});
  assign x_bounce = (x_sum < 13'sd0) || (x_sum > X_MAX);
  assign x_clamp = (x_sum < 13'sd0) ? 11'd0 :
                   (x_sum > X_MAX)  ? 11'(SCREEN_W - 1) : x_sum[10:0];
  // -16 has no positive 5-bit twin; bounce it to the fastest representable speed
  assign vx_neg  = (vx == -5'sd16) ? 5'sd15 : -vx;
  assign sep_sum = {1'b0, sep} + 9'(SPLIT_DX);
  assign sep_sat = sep_sum[8] ? 8'hFF : sep_sum[7:0];
  assign retire  = vy[7] && (y_step > RETIRE_Y);
  assign accept  = (state == FLYING) && bus.slash_valid_in && bus.hit_in &&
                   (bus.slash_run_in != 11'd0);

  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state <= IDLE;
      x     <= '0;
      y     <= Y_START;
      vy    <= '0;
      vx    <= '0;
      sep   <= '0;
      split <= 1'b0;
      run   <= '0;
      rise  <= '0;
      gone  <= 1'b0;
    end else begin
      state <= state_nxt;
      x     <= x_nxt;
      y     <= y_nxt;
      vy    <= vy_nxt;
      vx    <= vx_nxt;
      sep   <= sep_nxt;
      split <= split_nxt;
      run   <= run_nxt;
      rise  <= rise_nxt;
      gone  <= gone_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    x_nxt     = x;
    y_nxt     = y;
    vy_nxt    = vy;
    vx_nxt    = vx;
    sep_nxt   = sep;
    split_nxt = split;
    run_nxt   = run;
    rise_nxt  = rise;
    gone_nxt  = gone;
    case (state)
      IDLE: begin
        if (bus.launch_in) begin
          state_nxt = FLYING;
          x_nxt     = bus.launch_x_in;
          y_nxt     = Y_START;
          vy_nxt    = 8'(LAUNCH_VY);
          vx_nxt    = bus.launch_vx_in;
          sep_nxt   = '0;
          split_nxt = 1'b0;
          run_nxt   = '0;
          rise_nxt  = '0;
        end
      end
      FLYING, SLICED: begin
        if (accept) begin
          state_nxt = SLICED;
          split_nxt = 1'b1;
          run_nxt   = bus.slash_run_in;
          rise_nxt  = bus.slash_rise_in;
        end
        if (bus.frame_tick_in) begin
          y_nxt  = y_step;
          vy_nxt = vy_sat;
          x_nxt  = x_clamp;
          if (x_bounce) vx_nxt = vx_neg;
          // separation only opens on ticks after the slice has landed
          if (state == SLICED) sep_nxt = sep_sat;
          if (retire) begin
            state_nxt = GONE;
            gone_nxt  = 1'b1;
          end
        end
      end
      GONE: begin
        if (bus.frame_tick_in) begin
          state_nxt = IDLE;
          gone_nxt  = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.x_out           = x;
  assign bus.y_out           = (state == IDLE) ? 10'd0 : y[9:0];
  assign bus.sep_out         = sep;
  assign bus.split_out       = split;
  assign bus.run_out         = run;
  assign bus.rise_out        = rise;
  assign bus.veggie_gone_out = gone;
  assign bus.busy_out        = (state != IDLE);

`ifdef SLICE_SCORE_EN
  logic [15:0] score;
  logic        slice_pulse;

  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    if (!rst_in) begin
      score       <= '0;
      slice_pulse <= 1'b0;
    end else begin
      slice_pulse <= accept;
      if (accept && (score != 16'hFFFF)) score <= score + 16'd1;
    end
  end

  assign bus.score_out       = score;
  assign bus.slice_pulse_out = slice_pulse;
`endif

endmodule

// File: tb/tb_veggie_slice_ctrl.sv
// Randomised bench for veggie_slice_ctrl against a frame-level behavioural model.
// Build with +define+SLICE_SCORE_EN to also check the score/pulse outputs.
module tb_veggie_slice_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  veggie_slice_ctrl_if vif();
  veggie_slice_ctrl dut (.pixel_clk_in(clk), .rst_in(rst_n), .bus(vif.slave));

  int checks = 0;
  int errors = 0;

  // Frame-level model of one veggie
  bit m_busy, m_gone, m_split, m_pulse;
  int m_x, m_y, m_vy, m_vx, m_sep, m_run, m_rise, m_score;

  logic [52:0] obs;
  assign obs = {vif.x_out, vif.y_out, vif.sep_out, vif.split_out, vif.run_out,
                vif.rise_out, vif.veggie_gone_out, vif.busy_out};

  function automatic logic [52:0] exp_vec();
    logic [9:0] ey;
    ey = m_busy ? 10'(m_y) : 10'd0;
    return {11'(m_x), ey, 8'(m_sep), m_split, 11'(m_run), 10'(m_rise), m_gone, m_busy};
  endfunction

  task automatic model_reset();
    m_busy = 0; m_gone = 0; m_split = 0; m_pulse = 0;
    m_x = 0; m_y = 768; m_vy = 0; m_vx = 0; m_sep = 0; m_run = 0; m_rise = 0; m_score = 0;
  endtask

  task automatic clear_inputs();
    vif.frame_tick_in = 0; vif.launch_in = 0; vif.launch_x_in = 0; vif.launch_vx_in = 0;
    vif.slash_valid_in = 0; vif.slash_run_in = 0; vif.slash_rise_in = 0; vif.hit_in = 0;
  endtask

  // Advance the model by the inputs currently driven, then take one clock.
  task automatic cycle();
    bit acc;
    int ny, nx;
    m_pulse = 0;
    if (!rst_n) model_reset();
    else if (!m_busy) begin
      if (vif.launch_in) begin
        m_busy = 1; m_x = int'(vif.launch_x_in); m_y = 768; m_vy = 24;
        m_vx = int'($signed(vif.launch_vx_in)); m_sep = 0; m_split = 0; m_run = 0; m_rise = 0;
      end
    end else if (m_gone) begin
      if (vif.frame_tick_in) begin m_busy = 0; m_gone = 0; end
    end else begin
      acc = !m_split && vif.slash_valid_in && vif.hit_in && (vif.slash_run_in != 0);
      if (vif.frame_tick_in) begin
        ny = m_y - m_vy;
        if (m_vy < 0 && ny > 768 + 128) m_gone = 1;
        m_y = ny;
        m_vy = (m_vy - 1 < -128) ? -128 : m_vy - 1;
        nx = m_x + m_vx;
        if (nx < 0 || nx > 1023) begin
          nx = (nx < 0) ? 0 : 1023;
          m_vx = -m_vx;
          if (m_vx > 15) m_vx = 15;
        end
        m_x = nx;
        if (m_split) m_sep = (m_sep + 2 > 255) ? 255 : m_sep + 2;
      end
      if (acc) begin
        m_split = 1; m_run = int'(vif.slash_run_in); m_rise = int'(vif.slash_rise_in);
        m_pulse = 1;
        if (m_score < 65535) m_score++;
      end
    end
    @(posedge clk);
    #1;
    vif.frame_tick_in = 0; vif.launch_in = 0; vif.slash_valid_in = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    cycle();
    rst_n = 1;
    cycle();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      rst_n = 0;
      vif.frame_tick_in = 1'($urandom); vif.launch_in = 1'($urandom);
      vif.launch_x_in = 11'($urandom); vif.launch_vx_in = 5'($urandom);
      vif.slash_valid_in = 1'($urandom); vif.slash_run_in = 11'($urandom);
      vif.slash_rise_in = 10'($urandom); vif.hit_in = 1'($urandom);
      cycle();
      checks++;
      if (obs !== 53'd0) begin
        errors++; $display("FAIL reset_outputs: got %h, want 0", obs);
      end
`ifdef SLICE_SCORE_EN
      checks++;
      if ({vif.score_out, vif.slice_pulse_out} !== 17'd0) begin
        errors++; $display("FAIL reset_score: got %h, want 0", {vif.score_out, vif.slice_pulse_out});
      end
`endif
    end
    clear_inputs();
    rst_n = 1;
    cycle();
  endtask

  task automatic test_flight();
    int gone_tick = 0;
    int t = 0;
    vif.launch_in = 1; vif.launch_x_in = 11'd500; vif.launch_vx_in = 5'd0;
    vif.frame_tick_in = 1;  // launch wins; no physics on this tick
    cycle();
    checks++;
    if (obs !== exp_vec() || vif.y_out !== 10'd768) begin
      errors++; $display("FAIL flight_launch: got %h, want %h", obs, exp_vec());
    end
    while (vif.busy_out && t < 80) begin
      t++;
      vif.frame_tick_in = 1;
      cycle();
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL flight_tick%0d: got %h, want %h", t, obs, exp_vec());
      end
      if (t == 1) begin
        checks++;
        if (vif.y_out !== 10'd744) begin
          errors++; $display("FAIL flight_first_y: got %0d, want 744", vif.y_out);
        end
      end
      if (t == 49) begin
        checks++;
        if (vif.y_out !== 10'd768) begin
          errors++; $display("FAIL flight_return_y: got %0d, want 768", vif.y_out);
        end
      end
      if (vif.veggie_gone_out && gone_tick == 0) gone_tick = t;
      cycle();
      cycle();
    end
    checks++;
    if (gone_tick != 54 || vif.busy_out !== 1'b0 || t != 55) begin
      errors++; $display("FAIL flight_retire: gone at tick %0d idle at %0d, want 54 and 55", gone_tick, t);
    end
  endtask

  task automatic test_slice();
    do_reset();
    vif.launch_in = 1; vif.launch_x_in = 11'd300; vif.launch_vx_in = 5'd1;
    cycle();
    for (int i = 0; i < 3; i++) begin vif.frame_tick_in = 1; cycle(); end
    vif.slash_valid_in = 1; vif.hit_in = 1; vif.slash_run_in = 11'd40; vif.slash_rise_in = 10'd10;
    cycle();
    checks++;
    if ({vif.split_out, vif.run_out, vif.rise_out, vif.sep_out} !== {1'b1, 11'd40, 10'd10, 8'd0}) begin
      errors++; $display("FAIL slice_latch: got split=%b run=%0d rise=%0d sep=%0d, want 1/40/10/0",
                         vif.split_out, vif.run_out, vif.rise_out, vif.sep_out);
    end
    for (int k = 1; k <= 3; k++) begin
      vif.slash_valid_in = 1; vif.hit_in = 1; vif.slash_run_in = 11'd99;  // ignored once sliced
      vif.frame_tick_in = 1;
      cycle();
      checks++;
      if (vif.sep_out !== 8'(2 * k) || vif.run_out !== 11'd40 || obs !== exp_vec()) begin
        errors++; $display("FAIL slice_sep%0d: got sep=%0d run=%0d, want %0d/40", k, vif.sep_out, vif.run_out, 2 * k);
      end
    end
  endtask

  task automatic test_reject();
    do_reset();
    vif.launch_in = 1; vif.launch_x_in = 11'd200; vif.launch_vx_in = 5'd3;
    cycle();
    vif.frame_tick_in = 1; cycle();
    vif.slash_valid_in = 1; vif.hit_in = 1; vif.slash_run_in = 11'd0; vif.slash_rise_in = 10'd5;
    cycle();
    vif.slash_valid_in = 1; vif.hit_in = 0; vif.slash_run_in = 11'd40;
    cycle();
    vif.launch_in = 1; vif.launch_x_in = 11'd900; vif.launch_vx_in = 5'd9;
    cycle();
    checks++;
    if (vif.split_out !== 1'b0 || vif.x_out !== 11'd203 || obs !== exp_vec()) begin
      errors++; $display("FAIL reject: got split=%b x=%0d, want 0/203", vif.split_out, vif.x_out);
    end
    vif.frame_tick_in = 1; cycle();
    rst_n = 0;
    #1;
    checks++;
    if (obs !== 53'd0) begin
      errors++; $display("FAIL midflight_reset: got %h, want 0", obs);
    end
    cycle();
    rst_n = 1;
    cycle();
  endtask

  task automatic test_bounce();
    do_reset();
    vif.launch_in = 1; vif.launch_x_in = 11'd1020; vif.launch_vx_in = 5'd7;
    cycle();
    vif.frame_tick_in = 1; cycle();
    vif.frame_tick_in = 1; cycle();
    checks++;
    if (vif.x_out !== 11'd1016 || obs !== exp_vec()) begin
      errors++; $display("FAIL bounce_right: got x=%0d, want 1016 after clamp at 1023", vif.x_out);
    end
    do_reset();
    vif.launch_in = 1; vif.launch_x_in = 11'd3; vif.launch_vx_in = 5'h19;  // -7
    cycle();
    vif.frame_tick_in = 1; cycle();
    checks++;
    if (vif.x_out !== 11'd0) begin
      errors++; $display("FAIL bounce_left_clamp: got x=%0d, want 0", vif.x_out);
    end
    vif.frame_tick_in = 1; cycle();
    checks++;
    if (vif.x_out !== 11'd7 || obs !== exp_vec()) begin
      errors++; $display("FAIL bounce_left: got x=%0d, want 7", vif.x_out);
    end
  endtask

  task automatic test_coincident();
    do_reset();
    vif.launch_in = 1; vif.launch_x_in = 11'd600; vif.launch_vx_in = 5'd0;
    cycle();
    vif.frame_tick_in = 1; cycle();
    vif.frame_tick_in = 1; vif.slash_valid_in = 1; vif.hit_in = 1;
    vif.slash_run_in = 11'd12; vif.slash_rise_in = 10'd700;
    cycle();
    checks++;
    if (vif.split_out !== 1'b1 || vif.sep_out !== 8'd0 || vif.y_out !== 10'd721 || obs !== exp_vec()) begin
      errors++; $display("FAIL coincident: got split=%b sep=%0d y=%0d, want 1/0/721", vif.split_out, vif.sep_out, vif.y_out);
    end
`ifdef SLICE_SCORE_EN
    checks++;
    if (vif.score_out !== 16'd1 || vif.slice_pulse_out !== 1'b1) begin
      errors++; $display("FAIL coincident_score: got score=%0d pulse=%b, want 1/1", vif.score_out, vif.slice_pulse_out);
    end
`endif
    vif.frame_tick_in = 1; cycle();
    checks++;
    if (vif.sep_out !== 8'd2) begin
      errors++; $display("FAIL coincident_sep: got %0d, want 2", vif.sep_out);
    end
`ifdef SLICE_SCORE_EN
    checks++;
    if (vif.slice_pulse_out !== 1'b0) begin
      errors++; $display("FAIL coincident_pulse: pulse still %b, want 0", vif.slice_pulse_out);
    end
`endif
  endtask

  task automatic test_random();
    int bad = 0;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      vif.frame_tick_in = ($urandom_range(0, 2) == 0);
      vif.launch_in = ($urandom_range(0, 7) == 0);
      vif.launch_x_in = 11'($urandom_range(0, 1023));
      vif.launch_vx_in = 5'($urandom);
      vif.slash_valid_in = ($urandom_range(0, 19) == 0);
      vif.hit_in = 1'($urandom);
      vif.slash_run_in = ($urandom_range(0, 3) == 0) ? 11'd0 : 11'($urandom);
      vif.slash_rise_in = 10'($urandom);
      cycle();
      checks++;
      if (obs !== exp_vec()) begin
        errors++; bad++;
        if (bad < 10) $display("FAIL random_cycle%0d: got %h, want %h", i, obs, exp_vec());
      end
`ifdef SLICE_SCORE_EN
      checks++;
      if (vif.score_out !== 16'(m_score) || vif.slice_pulse_out !== m_pulse) begin
        errors++; bad++;
        if (bad < 10) $display("FAIL random_score%0d: got %0d/%b, want %0d/%b", i, vif.score_out, vif.slice_pulse_out, m_score, m_pulse);
      end
`endif
    end
  endtask

  initial begin
    clear_inputs();
    model_reset();
    test_reset();
    test_flight();
    test_slice();
    test_reject();
    test_bounce();
    test_coincident();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
